// File: rtl/led_matrix_pkg.sv
// Shared helpers for the LED matrix scanner: frame bit addressing and row pin polarity.
package led_matrix_pkg;

    function automatic int cell_idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

    // Level that keeps a row dark, given whether rows light on a low level.
    function automatic logic row_inactive_level(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Gated binary-to-one-hot decoder used for the column drive.
module onehot_decoder #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          ena,
    input  logic [IW-1:0] index,
    output logic [N-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (ena && (index == IW'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// Self-timed column scanner with PWM dimming, blanking and a tear-free double-buffered frame store.
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int ROWS           = 8,
    parameter int COLS           = 8,
    parameter int DWELL_CYCLES   = 1024,
    parameter int PWM_BITS       = 4,
    parameter int BLANK_CYCLES   = 2,
    parameter bit ROW_ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [ROWS*COLS-1:0] frame,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    input  logic [PWM_BITS-1:0]  brightness,
    output logic [ROWS-1:0]      rows,
    output logic [COLS-1:0]      cols,
    output logic                 frame_done
);

    localparam int   XW      = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int   DW      = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic ROW_OFF = row_inactive_level(ROW_ACTIVE_LOW);

    if ((DWELL_CYCLES % (1 << PWM_BITS)) != 0) begin : g_bad_dwell
        $error("led_matrix_scanner: DWELL_CYCLES must be a multiple of 2**PWM_BITS");
    end
    if (BLANK_CYCLES >= DWELL_CYCLES) begin : g_bad_blank
        $error("led_matrix_scanner: BLANK_CYCLES must be smaller than DWELL_CYCLES");
    end
    if (ROWS < 1 || ROWS > 16 || COLS < 1 || COLS > 16) begin : g_bad_size
        $error("led_matrix_scanner: ROWS and COLS must be in 1..16");
    end

    logic [XW-1:0]        x_q;
    logic [DW-1:0]        d_q;
    logic [ROWS*COLS-1:0] display_q;
    logic [ROWS*COLS-1:0] shadow_q;
    logic                 pending_q;

    logic                 last_dwell;
    logic                 last_col;
    logic                 frame_end;
    logic                 accept;
    logic                 swap;
    logic [PWM_BITS-1:0]  phase;
    logic                 lit;
    logic [ROWS-1:0]      rows_next;
    logic [COLS-1:0]      cols_next;

    assign last_dwell  = (d_q == DW'(DWELL_CYCLES - 1));
    assign last_col    = (x_q == XW'(COLS - 1));
    assign frame_end   = ena & last_dwell & last_col;
    assign frame_ready = ~pending_q & ~rst;
    assign accept      = frame_valid & frame_ready;
    // A disabled scanner shows nothing, so a waiting grid can be swapped in without tearing.
    assign swap        = pending_q & (frame_end | ~ena);
    assign phase       = d_q[PWM_BITS-1:0];
    assign lit         = ena & (d_q >= DW'(BLANK_CYCLES)) & (phase < brightness);

    // Scan index x shows cell column COLS-1-x; cell row r lands on pin ROWS-1-r.
    always_comb begin
        rows_next = {ROWS{ROW_OFF}};
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (lit && (x_q == XW'(COLS - 1 - c)) && display_q[cell_idx(r, c, COLS)]) begin
                    rows_next[ROWS-1-r] = ~ROW_OFF;
                end
            end
        end
    end

    onehot_decoder #(
        .N  (COLS),
        .IW (XW)
    ) u_col_dec (
        .ena    (lit),
        .index  (x_q),
        .onehot (cols_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q        <= '0;
            d_q        <= '0;
            display_q  <= '0;
            shadow_q   <= '0;
            pending_q  <= 1'b0;
            rows       <= {ROWS{ROW_OFF}};
            cols       <= '0;
            frame_done <= 1'b0;
        end else begin
            if (!ena) begin
                x_q <= '0;
                d_q <= '0;
            end else if (last_dwell) begin
                d_q <= '0;
                x_q <= last_col ? '0 : x_q + XW'(1);
            end else begin
                d_q <= d_q + DW'(1);
            end

            if (accept) begin
                shadow_q  <= frame;
                pending_q <= 1'b1;
            end else if (swap) begin
                display_q <= shadow_q;
                pending_q <= 1'b0;
            end

            rows       <= rows_next;
            cols       <= cols_next;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Randomised and directed bench for led_matrix_scanner against a frame-time reference model.
module tb_led_matrix_scanner;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int DWELL = 16;
    localparam int FRAME = COLS * DWELL;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [63:0] frame;
    logic        frame_valid;
    logic        frame_ready;
    logic [1:0]  brightness;
    logic [7:0]  rows;
    logic [7:0]  cols;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // Reference model: t counts enabled cycles since the scan last restarted.
    int          m_t;
    logic [63:0] m_disp;
    logic [63:0] m_shad;
    bit          m_pend;

    led_matrix_scanner #(
        .ROWS           (ROWS),
        .COLS           (COLS),
        .DWELL_CYCLES   (DWELL),
        .PWM_BITS       (2),
        .BLANK_CYCLES   (1),
        .ROW_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .brightness  (brightness),
        .rows        (rows),
        .cols        (cols),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic e, input logic fv,
                                  input logic [63:0] f, input logic [1:0] b);
        int   x, d, col;
        bit   lit, acc, swp;
        logic [7:0] e_rows, e_cols;
        logic       e_done;
        @(negedge clk);
        rst = r; ena = e; frame_valid = fv; frame = f; brightness = b;
        #1 check_output("frame_ready", {63'd0, frame_ready}, {63'd0, (!m_pend && !r)});

        x      = (m_t / DWELL) % COLS;
        d      = m_t % DWELL;
        col    = COLS - 1 - x;
        lit    = !r && e && (d >= 1) && ((d % 4) < int'(b));
        e_cols = lit ? 8'(1 << x) : 8'h00;
        e_rows = 8'hFF;
        for (int rr = 0; rr < ROWS; rr++) begin
            if (lit && m_disp[rr * COLS + col]) e_rows[ROWS-1-rr] = 1'b0;
        end
        e_done = !r && e && ((m_t % FRAME) == FRAME - 1);

        if (r) begin
            m_t = 0; m_disp = '0; m_shad = '0; m_pend = 0;
        end else begin
            acc = fv && !m_pend;
            swp = m_pend && (e_done || !e);
            if (acc) begin m_shad = f; m_pend = 1; end
            if (swp) begin m_disp = m_shad; m_pend = 0; end
            m_t = e ? m_t + 1 : 0;
        end

        @(posedge clk);
        #1;
        check_output("rows", {56'd0, rows}, {56'd0, e_rows});
        check_output("cols", {56'd0, cols}, {56'd0, e_cols});
        check_output("frame_done", {63'd0, frame_done}, {63'd0, e_done});
    endtask

    initial begin
        int          first;
        int          cnt, bad;
        logic [63:0] g;
        rst = 1'b1; ena = 1'b0; frame_valid = 1'b0; frame = '0; brightness = '0;
        m_t = 0; m_disp = '0; m_shad = '0; m_pend = 0;

        // Reset, then first frame_done after a full frame of enable.
        repeat (3) apply_stimulus(1, 0, 0, '0, 2'd3);
        first = -1;
        for (int i = 1; i <= 130; i++) begin
            apply_stimulus(0, 1, 0, '0, 2'd3);
            if (frame_done && first < 0) first = i;
        end
        check_output("first_done", 64'(first), 64'(FRAME));

        // Single lit cell (0,0) at brightness 3.
        apply_stimulus(0, 1, 1, 64'd1, 2'd3);
        for (int i = 0; i < 300 && !frame_done; i++) apply_stimulus(0, 1, 0, '0, 2'd3);
        cnt = 0; bad = 0;
        for (int i = 0; i < FRAME; i++) begin
            apply_stimulus(0, 1, 0, '0, 2'd3);
            if (cols == 8'h80 && rows == 8'h7F) cnt++;
            if (cols != 8'h80 && rows != 8'hFF) bad++;
        end
        check_output("single_cell_lit", 64'(cnt), 64'd11);
        check_output("single_cell_others", 64'(bad), 64'd0);

        // Backpressure: A accepted, B held until the post-swap cycle.
        apply_stimulus(0, 1, 1, {$urandom, $urandom}, 2'd2);
        g = {$urandom, $urandom};
        for (int i = 0; i < 300 && m_pend; i++) apply_stimulus(0, 1, 1, g, 2'd2);
        apply_stimulus(0, 1, 1, g, 2'd2);
        repeat (2 * FRAME + 4) apply_stimulus(0, 1, 0, '0, 2'd2);

        // Brightness zero keeps everything dark.
        apply_stimulus(0, 1, 1, '1, 2'd0);
        cnt = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            apply_stimulus(0, 1, 0, '0, 2'd0);
            if (cols != 8'h00 || rows != 8'hFF) cnt++;
        end
        check_output("bright0_dark", 64'(cnt), 64'd0);

        // Enable drop at x=3 with a pending grid.
        for (int i = 0; i < 300 && m_t % FRAME != 3 * DWELL + 4; i++) apply_stimulus(0, 1, 0, '0, 2'd3);
        apply_stimulus(0, 1, 1, {$urandom, $urandom}, 2'd3);
        apply_stimulus(0, 0, 0, '0, 2'd3);
        apply_stimulus(0, 0, 0, '0, 2'd3);
        first = -1;
        for (int i = 0; i < 40; i++) begin
            apply_stimulus(0, 1, 0, '0, 2'd3);
            if (cols != 8'h00 && first < 0) first = int'(cols);
        end
        check_output("reenable_first_col", 64'(first), 64'h01);

        // Mid-frame reset while a grid is pending.
        apply_stimulus(0, 1, 1, '1, 2'd3);
        repeat (20) apply_stimulus(0, 1, 0, '0, 2'd3);
        repeat (2) apply_stimulus(1, 1, 0, '0, 2'd3);
        cnt = 0;
        for (int i = 0; i < 2 * FRAME + 10; i++) begin
            apply_stimulus(0, 1, 0, '0, 2'd3);
            if (rows != 8'hFF) cnt++;
        end
        check_output("reset_no_stale", 64'(cnt), 64'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) != 0),
                           ($urandom_range(0, 3) == 0), {$urandom, $urandom},
                           2'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Self-timed, parametrised successor to the single-column LED array driver. It owns its own column-scan counter, per-column dwell timer, and PWM brightness control. A double-buffered frame store with a valid/ready load port means the Conway core can push a new grid at any time without tearing. It sits between the game-of-life state register and the physical row/column pins of the LED matrix.

## Interface
- `ROWS`, 8: matrix rows; 1..16.
- `COLS`, 8: matrix columns, scanned one at a time; 1..16.
- `DWELL_CYCLES`, 1024: clock cycles each column is held; must be a multiple of 2^`PWM_BITS`; `$error` otherwise.
- `PWM_BITS`, 4: brightness resolution.
- `BLANK_CYCLES`, 2: forced-dark cycles at the start of each dwell (anti-ghosting); must be < `DWELL_CYCLES`.
- `ROW_ACTIVE_LOW`, 1: row pin level that lights an LED is 0 when set.
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `ena`, in, 1: scan enable.
- `frame`, in, `ROWS*COLS`: cell (r,c) is bit `r*COLS+c`; 1 = lit.
- `frame_valid`, in, 1: `frame` holds a new grid.
- `frame_ready`, out, 1: shadow buffer can accept a grid.
- `brightness`, in, `PWM_BITS`: duty numerator; 0 = dark.
- `rows`, out, `ROWS`: row drive.
- `cols`, out, `COLS`: one-hot column drive, active-high.
- `frame_done`, out, 1: one-cycle pulse on the last displayed cycle of each frame.

## Operation
- **State:**
  - scan index `x` (0..`COLS`-1)
  - dwell counter `d` (0..`DWELL_CYCLES`-1)
  - display buffer
  - shadow buffer
  - `pending` flag
- **Scan:**
  - With `ena`=1, `d` increments every cycle.
  - When `d`=`DWELL_CYCLES`-1, `d` wraps to 0 and `x` advances; `x`=`COLS`-1 wraps to 0.
  - Frame period is `COLS*DWELL_CYCLES` cycles.
- **Column mapping:**
  - Scan index `x` drives `cols[x]` and shows cell column `c = COLS-1-x`.
  - Cell (r,c) drives `rows[ROWS-1-r]`.
- **Lit condition:** `ena` & `d >= BLANK_CYCLES` & `phase < brightness`, where `phase = d[PWM_BITS-1:0]`.
  - Lit: `cols` = one-hot(`x`); each row is at its active level iff its cell is 1.
  - Otherwise the outputs are blank: `cols`=0 and all rows at their inactive level.
- **Brightness:**
  - Sampled every cycle.
  - The maximum value gives duty (2^P-1)/2^P.
- **Load handshake:**
  - `frame_ready` = `~pending & ~rst`.
  - On `frame_valid & frame_ready`: shadow <= `frame`, `pending` <= 1.
  - `frame_valid` without `frame_ready` is ignored; the producer holds the grid.
- **Swap:**
  - Occurs at the frame boundary (`x`=`COLS`-1, `d`=`DWELL_CYCLES`-1, `ena`=1) with `pending`=1: display <= shadow, `pending` <= 0.
  - `ena`=0 with `pending`=1: swap on the next cycle.
  - Accept and swap never coincide, because `frame_ready`=0 whenever `pending`=1.
- **Enable low:**
  - `x`, `d` <= 0, so the scan restarts at column 0 on re-enable.
  - Outputs blank; `frame_done` stays 0.
- **Reset:**
  - `x`, `d`, display, shadow, `pending` <= 0.
  - `rows` = all-inactive, `cols`=0, `frame_done`=0, `frame_ready`=0.
  - Mid-frame reset discards both buffers.

## Timing
- `rows`, `cols`, and `frame_done` are registered and reflect the (`x`, `d`, display) state of the previous cycle, i.e. 1-cycle latency.
- `frame_done` is high in the same output cycle as the final `cols`=one-hot(`COLS`-1) dwell slot.
- `frame_ready` is combinational from `pending`/`rst`.
- The first cycle after `rst` deasserts: `frame_ready`=1.
- An accepted grid is visible from the first cycle of the next frame, at most `COLS*DWELL_CYCLES`+1 cycles after acceptance.

## Structure
- Package `led_matrix_pkg`: helper functions `cell_idx(r,c)` and `row_inactive_level(ROW_ACTIVE_LOW)`.
- Sub-module `onehot_decoder` (parameter `N`; inputs `ena`, index; output `N`-bit one-hot) generates `cols`.
- Everything else lives in `led_matrix_scanner`.

## Test plan
All scenarios use `ROWS`=`COLS`=8, `DWELL_CYCLES`=16, `PWM_BITS`=2, `BLANK_CYCLES`=1, `ROW_ACTIVE_LOW`=1.
- **Reset:** hold `rst` 3 cycles → `rows`=8'hFF, `cols`=0, `frame_ready`=0; after release `frame_ready`=1 and `frame_done` first pulses after 128 cycles of `ena`.
- **Single cell:** load `frame`=bit 0 (cell 0,0), `brightness`=3, wait for swap → during the `cols`=8'h80 dwell, `rows`=8'h7F on 11 of 16 cycles (`d`≠0, `phase`<3); other columns show `rows`=8'hFF.
- **Backpressure:** accept grid A, then present B → `frame_ready`=0 until the swap on the cycle after `frame_done`. A is displayed for one frame; B is accepted the cycle after, and appears one frame later. Display never changes mid-frame.
- **Brightness 0:** all-ones frame → `cols`=0, `rows`=8'hFF for 256 cycles.
- **Enable drop:** drop `ena` at `x`=3 → blank next cycle and a pending grid swaps immediately. On re-raise, the first lit column is `cols`=8'h01.
- **Mid-frame reset:** reset with `pending`=1 → display all-zero after release and `frame_ready`=1; no stale grid appears.
